arb_burst_ctrl: RTL and testbench
=================================

Name: arb_burst_ctrl

Overview:
- Downstream stage of the two-requester arbiter: consumes gnt_0/gnt_1 and moves the granted requester's burst onto one shared valid/ready sink.
- Pops one word per accepted beat from the granted source and counts beats to the programmed length.
- Pulses done to the owning requester so it can drop its req.
- Aborts cleanly if the grant is withdrawn early.

Parameters:
DATA_W, 8, data word width
LEN_W, 4, burst-length field width; burst = len+1 beats (1..2**LEN_W)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
gnt_0  in  1  grant to requester 0, from arbiter
gnt_1  in  1  grant to requester 1, from arbiter
len_0  in  LEN_W  requester 0 burst length minus one; sampled at burst start
len_1  in  LEN_W  requester 1 burst length minus one
data_0  in  DATA_W  requester 0 current word
data_1  in  DATA_W  requester 1 current word
out_ready  in  1  sink ready
out_valid  out  1  beat valid to sink
out_data  out  DATA_W  beat data
out_src  out  1  source id of current beat (0/1)
pop_0  out  1  requester 0 word consumed this cycle
pop_1  out  1  requester 1 word consumed this cycle
done_0  out  1  one-cycle pulse: requester 0 burst complete
done_1  out  1  one-cycle pulse: requester 1 burst complete
err  out  1  one-cycle pulse: protocol violation or abort

Behaviour:
- Reset (async, asserted): state=IDLE, beat counter=0, src=0. Registered outputs go 0 immediately: out_valid, done_0/1, err, out_src. pop_0/1=0 because out_valid=0.
- Reset mid-burst discards the burst; no done or err is generated.
- States: IDLE, BURST, WAIT_REL. Owner src is a registered bit.
- IDLE:
  - gnt_0=1, gnt_1=0 at edge: cnt<=len_0, src<=0, ->BURST.
  - gnt_1=1, gnt_0=0 at edge: cnt<=len_1, src<=1, ->BURST.
  - Both high: err pulse, stay IDLE.
  - Neither: stay IDLE.
- Latency: out_valid is first high in the cycle after the edge that samples the grant (1 cycle).
- BURST:
  - out_valid=1 (from state).
  - out_data = src ? data_1 : data_0 (combinational).
  - out_src = src.
  - Transfer = out_valid & out_ready.
  - pop_src = transfer (combinational); the other pop = 0.
  - Transfer with cnt>0: cnt<=cnt-1.
  - Transfer with cnt==0 (last beat): done_src<=1 for one cycle; ->WAIT_REL.
  - out_ready low: hold state; out_data follows the source unchanged, because the source does not advance without pop.
  - Grant of owner low at any edge in BURST (before last transfer): ->IDLE, err pulse, no done. A transfer in that same cycle still counts as popped.
  - Last-beat transfer and owner-grant drop on the same edge: treated as completion (done, no err); ->WAIT_REL.
- WAIT_REL:
  - out_valid=0.
  - Stay until owner grant is low, then ->IDLE on that edge.
  - The other grant is ignored here. It cannot be legal while the owner grant is held; if seen high, err pulse.
- Only one of done_0/done_1 is high per cycle; done never coincides with err except per the rules above.
- cnt is LEN_W bits and never wraps (decrement only when >0).
- Max burst 2**LEN_W beats.
- No combinational path from gnt_* to out_*.

Decomposition:
- Shared package arb_pkg:
  - state enum (IDLE, BURST, WAIT_REL).
  - src_t (1-bit source id).
  - Default DATA_W/LEN_W constants.
- No sub-module is needed; the counter and FSM sit in one module.

Test Plan:
- len_0=3, gnt_0 held, out_ready=1: 4 beats, out_src=0, pop_0 high 4 cycles, then done_0 pulses once. gnt_0 dropped -> IDLE.
- len_1=2, out_ready toggling 1,0,1,0,1: exactly 3 transfers; pop_1 only on ready cycles; done_1 after third transfer.
- len_0=0: single beat, out_valid 1 cycle, done_0 the next cycle.
- gnt_0 and gnt_1 both high in IDLE: err=1 one cycle, out_valid stays 0.
- len_1=7, gnt_1 dropped after 2 transfers: err pulse, no done_1, out_valid=0 next cycle.
- Reset asserted mid-burst (beat 2 of 5): out_valid/done/err go 0 without waiting for a clock edge. After release, a fresh gnt_0 burst with len_0=1 completes normally in 2 beats.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default widths for the burst controller that sits behind
// the two-requester arbiter.
package arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  typedef logic src_t;

endpackage

// File: rtl/arb_burst_ctrl_if.sv
// Requester/sink bundle of the burst controller. The slave modport is the
// controller's view; the master modport is the surrounding logic's view.
interface arb_burst_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              gnt_0;
  logic              gnt_1;
  logic [LEN_W-1:0]  len_0;
  logic [LEN_W-1:0]  len_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              pop_0;
  logic              pop_1;
  logic              done_0;
  logic              done_1;
  logic              err;

  modport slave (
    input  gnt_0, gnt_1, len_0, len_1, data_0, data_1, out_ready,
    output out_valid, out_data, out_src, pop_0, pop_1, done_0, done_1, err
  );

  modport master (
    output gnt_0, gnt_1, len_0, len_1, data_0, data_1, out_ready,
    input  out_valid, out_data, out_src, pop_0, pop_1, done_0, done_1, err
  );
endinterface

// File: rtl/arb_burst_ctrl.sv
// Moves the granted requester's burst onto one valid/ready sink, counting
// beats down from the sampled length and signalling done or abort.
module arb_burst_ctrl
  import arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  arb_burst_ctrl_if.slave   bus
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  src_t              src_q, src_d;
  logic              done_0_q, done_0_d;
  logic              done_1_q, done_1_d;
  logic              err_q, err_d;

  logic              transfer;
  logic              owner_gnt;
  logic              other_gnt;
  logic [DATA_W-1:0] data_mux;

  // Outputs depend only on registered state and out_ready, never on the grants.
  assign bus.out_valid = (state_q == BURST);
  assign transfer      = bus.out_valid & bus.out_ready;
  assign bus.pop_0     = transfer & ~src_q;
  assign bus.pop_1     = transfer &  src_q;
  assign data_mux      = src_q ? bus.data_1 : bus.data_0;
  assign bus.out_data  = data_mux;
  assign bus.out_src   = src_q;
  assign bus.done_0    = done_0_q;
  assign bus.done_1    = done_1_q;
  assign bus.err       = err_q;

  assign owner_gnt = src_q ? bus.gnt_1 : bus.gnt_0;
  assign other_gnt = src_q ? bus.gnt_0 : bus.gnt_1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      src_q    <= 1'b0;
      done_0_q <= 1'b0;
      done_1_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      done_0_q <= done_0_d;
      done_1_q <= done_1_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    done_0_d = 1'b0;
    done_1_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.gnt_0 && bus.gnt_1) begin
          err_d = 1'b1;
        end else if (bus.gnt_0) begin
          cnt_d   = bus.len_0;
          src_d   = 1'b0;
          state_d = BURST;
        end else if (bus.gnt_1) begin
          cnt_d   = bus.len_1;
          src_d   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        // A last-beat transfer wins over a simultaneous grant drop.
        if (transfer && (cnt_q == '0)) begin
          done_0_d = ~src_q;
          done_1_d =  src_q;
          state_d  = WAIT_REL;
        end else if (!owner_gnt) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (transfer) begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      WAIT_REL: begin
        if (other_gnt) err_d = 1'b1;
        if (!owner_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arb_burst_ctrl.sv
// Directed bench for arb_burst_ctrl: bursts, back-pressure, aborts, reset.
module tb_arb_burst_ctrl;
  import arb_pkg::*;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  arb_burst_ctrl_if #(.DATA_W(8), .LEN_W(4)) bus ();

  arb_burst_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.gnt_0 = 0; bus.gnt_1 = 0; bus.len_0 = 0; bus.len_1 = 0;
    bus.data_0 = 8'h00; bus.data_1 = 8'h00; bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if ({bus.done_0, bus.done_1, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.done_0, bus.done_1, bus.err}); end
    checks++; if ({bus.out_src, bus.pop_0, bus.pop_1} !== 3'b000) begin errors++; $display("FAIL reset_src_pop: got %b expected 000", {bus.out_src, bus.pop_0, bus.pop_1}); end
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_burst0();
    bus.len_0 = 4'd3; bus.gnt_0 = 1'b1; bus.out_ready = 1'b1; bus.data_1 = 8'hEE;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.data_0 = 8'h10 + 8'(i);
      #1;
      checks++; if ({bus.out_valid, bus.pop_0, bus.pop_1, bus.out_src} !== 4'b1100) begin errors++; $display("FAIL burst0_beat%0d_ctl: got %b expected 1100", i, {bus.out_valid, bus.pop_0, bus.pop_1, bus.out_src}); end
      checks++; if (bus.out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL burst0_beat%0d_data: got %h expected %h", i, bus.out_data, 8'h10 + 8'(i)); end
      checks++; if (bus.done_0 !== 1'b0) begin errors++; $display("FAIL burst0_beat%0d_early_done: got %b expected 0", i, bus.done_0); end
      step();
    end
    checks++; if ({bus.done_0, bus.out_valid, bus.err} !== 3'b100) begin errors++; $display("FAIL burst0_done: got %b expected 100", {bus.done_0, bus.out_valid, bus.err}); end
    step();
    checks++; if (bus.done_0 !== 1'b0) begin errors++; $display("FAIL burst0_done_pulse: got %b expected 0", bus.done_0); end
    bus.gnt_0 = 1'b0;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL burst0_idle: got %b expected 0", bus.out_valid); end
    $display("test_burst0 done: 4 beats src 0");
  endtask

  task automatic test_ready_toggle();
    logic [4:0] pat;
    int xfers;
    pat = 5'b10101;
    xfers = 0;
    bus.len_1 = 4'd2; bus.gnt_1 = 1'b1; bus.data_0 = 8'h33;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = pat[i];
      bus.data_1 = 8'h50 + 8'(xfers);
      #1;
      checks++; if ({bus.out_valid, bus.out_src, bus.pop_0, bus.pop_1} !== {3'b110, pat[i]}) begin errors++; $display("FAIL toggle_cyc%0d_ctl: got %b expected %b", i, {bus.out_valid, bus.out_src, bus.pop_0, bus.pop_1}, {3'b110, pat[i]}); end
      checks++; if (bus.out_data !== 8'h50 + 8'(xfers)) begin errors++; $display("FAIL toggle_cyc%0d_data: got %h expected %h", i, bus.out_data, 8'h50 + 8'(xfers)); end
      checks++; if (bus.done_1 !== 1'b0) begin errors++; $display("FAIL toggle_cyc%0d_early_done: got %b expected 0", i, bus.done_1); end
      step();
      if (pat[i]) xfers++;
    end
    checks++; if ({bus.done_1, bus.done_0, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL toggle_done: got %b expected 100", {bus.done_1, bus.done_0, bus.out_valid}); end
    bus.gnt_1 = 1'b0; bus.out_ready = 1'b1;
    step();
    step();
    $display("test_ready_toggle done: %0d transfers", xfers);
  endtask

  task automatic test_single();
    bus.len_0 = 4'd0; bus.gnt_0 = 1'b1; bus.out_ready = 1'b1;
    step();
    checks++; if ({bus.out_valid, bus.pop_0} !== 2'b11) begin errors++; $display("FAIL single_beat: got %b expected 11", {bus.out_valid, bus.pop_0}); end
    step();
    checks++; if ({bus.out_valid, bus.done_0} !== 2'b01) begin errors++; $display("FAIL single_done: got %b expected 01", {bus.out_valid, bus.done_0}); end
    bus.gnt_0 = 1'b0;
    step();
    step();
    $display("test_single done");
  endtask

  task automatic test_both_grants();
    bus.gnt_0 = 1'b1; bus.gnt_1 = 1'b1;
    step();
    checks++; if ({bus.err, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL both_err: got %b expected 10", {bus.err, bus.out_valid}); end
    bus.gnt_0 = 1'b0; bus.gnt_1 = 1'b0;
    step();
    checks++; if ({bus.err, bus.out_valid} !== 2'b00) begin errors++; $display("FAIL both_clear: got %b expected 00", {bus.err, bus.out_valid}); end
    $display("test_both_grants done");
  endtask

  task automatic test_abort();
    bus.len_1 = 4'd7; bus.gnt_1 = 1'b1; bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.pop_1 !== 1'b1) begin errors++; $display("FAIL abort_beat%0d_pop: got %b expected 1", i, bus.pop_1); end
      step();
    end
    bus.gnt_1 = 1'b0; bus.out_ready = 1'b0;
    step();
    checks++; if ({bus.err, bus.done_1, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL abort_err: got %b expected 100", {bus.err, bus.done_1, bus.out_valid}); end
    step();
    checks++; if ({bus.err, bus.done_1, bus.out_valid} !== 3'b000) begin errors++; $display("FAIL abort_after: got %b expected 000", {bus.err, bus.done_1, bus.out_valid}); end
    bus.out_ready = 1'b1;
    $display("test_abort done");
  endtask

  task automatic test_last_drop();
    bus.len_0 = 4'd0; bus.gnt_0 = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.gnt_0 = 1'b0;
    step();
    checks++; if ({bus.done_0, bus.err} !== 2'b10) begin errors++; $display("FAIL last_drop: got %b expected 10", {bus.done_0, bus.err}); end
    step();
    checks++; if ({bus.done_0, bus.err, bus.out_valid} !== 3'b000) begin errors++; $display("FAIL last_drop_idle: got %b expected 000", {bus.done_0, bus.err, bus.out_valid}); end
    $display("test_last_drop done");
  endtask

  task automatic test_reset_mid();
    bus.len_0 = 4'd4; bus.gnt_0 = 1'b1; bus.out_ready = 1'b1;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", bus.out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.pop_0, bus.done_0, bus.err} !== 4'b0000) begin errors++; $display("FAIL rstmid_async: got %b expected 0000", {bus.out_valid, bus.pop_0, bus.done_0, bus.err}); end
    bus.gnt_0 = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++; if ({bus.out_valid, bus.done_0, bus.err} !== 3'b000) begin errors++; $display("FAIL rstmid_quiet: got %b expected 000", {bus.out_valid, bus.done_0, bus.err}); end
    bus.len_0 = 4'd1; bus.gnt_0 = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++; if ({bus.out_valid, bus.pop_0, bus.done_0} !== 3'b110) begin errors++; $display("FAIL rstmid_beat%0d: got %b expected 110", i, {bus.out_valid, bus.pop_0, bus.done_0}); end
      step();
    end
    checks++; if ({bus.done_0, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_done: got %b expected 10", {bus.done_0, bus.out_valid}); end
    bus.gnt_0 = 1'b0;
    step();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_burst0();
    test_ready_toggle();
    test_single();
    test_both_grants();
    test_abort();
    test_last_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
